// File: rtl/stepgen_dds.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : stepgen_dds                                                   |
// | Purpose  : DDS step/direction generator with dir-setup and step timing.  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module stepgen_dds #(
   parameter int W = 10,
   parameter int F = 11,
   parameter int T = 4
) (
   input  logic             clk,
   input  logic             nRESET,
   input  logic             stepcnt,
   input  logic [F:0]       vel,
   input  logic [T-1:0]     dirtime,
   input  logic [T-1:0]     steptime,
   input  logic [1:0]       tap,
   output logic [W+F-1:0]   pos,
   output logic             step,
   output logic             dir
);

   localparam int IW = $clog2(W + F);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_DIRSETUP = 2'd1,
      S_STEPHI   = 2'd2,
      S_STEPLO   = 2'd3
   } state_t;

   state_t           r_state;
   logic [T-1:0]     r_timer;
   logic [W+F-1:0]   r_pos;
   logic             r_step;
   logic             r_dir;

   logic [W+F-1:0]   w_vel_ext;
   logic [W+F-1:0]   w_pos_next;
   logic [IW-1:0]    w_idx;
   logic             w_cross;
   logic             w_nd;
   logic             w_timer_zero;

   assign w_vel_ext    = {{(W-1){vel[F]}}, vel};
   assign w_pos_next   = r_pos + w_vel_ext;
   assign w_idx        = IW'(F) + {{(IW-2){1'b0}}, tap};
   // |vel| < 2^F guarantees at most one toggle of the monitored bit per update
   assign w_cross      = r_pos[w_idx] ^ w_pos_next[w_idx];
   assign w_nd         = ~vel[F];
   assign w_timer_zero = (r_timer == '0);

   always_ff @(posedge clk or negedge nRESET) begin
      if (!nRESET) begin
         r_state <= S_IDLE;
         r_timer <= '0;
         r_pos   <= '0;
         r_step  <= 1'b0;
         r_dir   <= 1'b0;
      end else if (stepcnt) begin
         case (r_state)
            S_IDLE: begin
               r_pos <= w_pos_next;
               if (w_cross) begin
                  if (w_nd != r_dir) begin
                     r_dir   <= w_nd;
                     r_timer <= dirtime;
                     r_state <= S_DIRSETUP;
                  end else begin
                     r_step  <= 1'b1;
                     r_timer <= steptime;
                     r_state <= S_STEPHI;
                  end
               end
            end
            S_DIRSETUP: begin
               if (w_timer_zero) begin
                  r_step  <= 1'b1;
                  r_timer <= steptime;
                  r_state <= S_STEPHI;
               end else begin
                  r_timer <= r_timer - T'(1);
               end
            end
            S_STEPHI: begin
               if (w_timer_zero) begin
                  r_step  <= 1'b0;
                  r_timer <= steptime;
                  r_state <= S_STEPLO;
               end else begin
                  r_timer <= r_timer - T'(1);
               end
            end
            S_STEPLO: begin
               if (w_timer_zero) begin
                  r_state <= S_IDLE;
               end else begin
                  r_timer <= r_timer - T'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign pos  = r_pos;
   assign step = r_step;
   assign dir  = r_dir;

endmodule
`default_nettype wire

// File: tb/tb_stepgen_dds.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_stepgen_dds                                                |
// | Purpose  : directed self-checking bench for stepgen_dds.                 |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_stepgen_dds;

   logic        clk = 1'b0;
   logic        nRESET = 1'b0;
   logic        stepcnt = 1'b0;
   logic [11:0] vel = '0;
   logic [3:0]  dirtime = '0;
   logic [3:0]  steptime = '0;
   logic [1:0]  tap = '0;
   logic [20:0] pos;
   logic        step;
   logic        dir;

   int n_checks = 0;
   int n_pass   = 0;
   int gap      = 0;

   stepgen_dds #(.W(10), .F(11), .T(4)) dut (
      .clk      (clk),
      .nRESET   (nRESET),
      .stepcnt  (stepcnt),
      .vel      (vel),
      .dirtime  (dirtime),
      .steptime (steptime),
      .tap      (tap),
      .pos      (pos),
      .step     (step),
      .dir      (dir)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   // Called at a negedge; leaves the bench at the negedge after one tick edge.
   task automatic tick();
      stepcnt = 1'b0;
      repeat (gap) @(negedge clk);
      stepcnt = 1'b1;
      @(negedge clk);
      stepcnt = 1'b0;
   endtask

   task automatic vec(input string tag, input int p, input bit s, input bit d);
      tick();
      check({tag, "_pos"},  32'(pos),  32'(p));
      check({tag, "_step"}, 32'(step), 32'(s));
      check({tag, "_dir"},  32'(dir),  32'(d));
   endtask

   task automatic do_reset();
      stepcnt = 1'b0;
      nRESET  = 1'b0;
      repeat (2) @(negedge clk);
      nRESET  = 1'b1;
   endtask

   task automatic tap_run(input int g);
      int   ticks;
      int   steps;
      logic prev;
      do_reset();
      gap = g; tap = 2'd2; vel = 12'd1024; dirtime = 4'd0; steptime = 4'd0;
      ticks = 0; steps = 0; prev = 1'b0;
      while (pos != 21'd32768 && ticks < 200) begin
         tick();
         ticks++;
         if (step && !prev) steps++;
         prev = step;
      end
      check("tap2_ticks", 32'(ticks), 32'd39);
      check("tap2_steps", 32'(steps), 32'd4);
      check("tap2_dir",   32'(dir),   32'd1);
      gap = 0;
   endtask

   initial begin
      // reset held with arbitrary inputs toggling
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         vel = 12'($urandom); tap = 2'($urandom); dirtime = 4'($urandom);
         steptime = 4'($urandom); stepcnt = 1'b1;
         @(negedge clk);
      end
      check("rst_pos",  32'(pos),  32'd0);
      check("rst_step", 32'(step), 32'd0);
      check("rst_dir",  32'(dir),  32'd0);
      stepcnt = 1'b0; vel = '0; tap = '0; dirtime = '0; steptime = '0;
      nRESET = 1'b1;
      repeat (50) tick();
      check("vel0_pos",  32'(pos),  32'd0);
      check("vel0_step", 32'(step), 32'd0);
      check("vel0_dir",  32'(dir),  32'd0);

      // forward from reset: direction setup on the first crossing
      do_reset();
      tap = 2'd0; vel = 12'd1024; dirtime = 4'd2; steptime = 4'd1;
      vec("f01", 1024, 0, 0);
      vec("f02", 2048, 0, 1);
      vec("f03", 2048, 0, 1);
      vec("f04", 2048, 0, 1);
      vec("f05", 2048, 1, 1);
      vec("f06", 2048, 1, 1);
      vec("f07", 2048, 0, 1);
      vec("f08", 2048, 0, 1);
      vec("f09", 2048, 0, 1);
      vec("f10", 3072, 0, 1);
      // steady direction: step rises on the crossing edge
      vec("f11", 4096, 1, 1);
      vec("f12", 4096, 1, 1);
      vec("f13", 4096, 0, 1);
      vec("f14", 4096, 0, 1);
      vec("f15", 4096, 0, 1);
      vec("f16", 5120, 0, 1);
      vec("f17", 6144, 1, 1);
      vec("f18", 6144, 1, 1);
      vec("f19", 6144, 0, 1);
      vec("f20", 6144, 0, 1);
      vec("f21", 6144, 0, 1);

      // reversal
      vel = 12'hC00;
      vec("r22", 5120, 0, 0);
      vec("r23", 5120, 0, 0);
      vec("r24", 5120, 0, 0);
      vec("r25", 5120, 1, 0);
      vec("r26", 5120, 1, 0);
      vec("r27", 5120, 0, 0);
      vec("r28", 5120, 0, 0);
      vec("r29", 5120, 0, 0);
      vec("r30", 4096, 0, 0);
      vec("r31", 3072, 1, 0);

      // asynchronous reset while step is high
      #2 nRESET = 1'b0;
      #1;
      check("mid_rst_pos",  32'(pos),  32'd0);
      check("mid_rst_step", 32'(step), 32'd0);
      check("mid_rst_dir",  32'(dir),  32'd0);
      @(negedge clk);
      nRESET = 1'b1;

      // reverse wrap below zero (no setup), then forward wrap back to zero
      vel = 12'hC00; tap = 2'd0; dirtime = 4'd1; steptime = 4'd1;
      vec("w01", 2096128, 1, 0);
      vec("w02", 2096128, 1, 0);
      vel = 12'd1024;  // must be ignored until IDLE
      vec("w03", 2096128, 0, 0);
      vec("w04", 2096128, 0, 0);
      vec("w05", 2096128, 0, 0);
      vec("w06", 0, 0, 1);
      vec("w07", 0, 0, 1);
      vec("w08", 0, 1, 1);

      // tap=2, every-cycle and sparse timebase
      tap_run(0);
      tap_run(63);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
